rv32i_clint: RTL and testbench
==============================

RV32I_CLINT -- requirements
Module: rv32i_clint

Interface
REQ-001 The block SHALL have one parameter: PRESCALE, default 1, meaning i_clk cycles per mtime increment (legal 1..65535).
REQ-002 The block SHALL have the port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port i_rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 The block SHALL have the port i_req, input, 1, bus request valid this cycle.
REQ-005 The block SHALL have the port i_we, input, 1, 1 = write, 0 = read; qualified by i_req.
REQ-006 The block SHALL have the port i_addr, input, 5, byte offset; only word-aligned offsets are decoded.
REQ-007 The block SHALL have the port i_wdata, input, 32, write data.
REQ-008 The block SHALL have the port o_ack, output, 1, request completion pulse.
REQ-009 The block SHALL have the port o_rdata, output, 32, read data, valid only while o_ack=1.
REQ-010 The block SHALL have the port i_ext_irq, input, 1, asynchronous external interrupt line.
REQ-011 The block SHALL have the port o_timer_interrupt, output, 1, drives the CSR unit's i_timer_interrupt.
REQ-012 The block SHALL have the port o_software_interrupt, output, 1, drives the CSR unit's i_software_interrupt.
REQ-013 The block SHALL have the port o_external_interrupt, output, 1, drives the CSR unit's i_external_interrupt.

Function
REQ-014 The register map SHALL be: 0x00 msip (bit0 only, other bits read 0), 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32], 0x10 mtime[31:0], 0x14 mtime[63:32].
REQ-015 Other offsets SHALL read 0 and ignore writes, and SHALL still be acknowledged.
REQ-016 Each cycle with i_req=1 SHALL produce o_ack=1 exactly one cycle later; back-to-back requests SHALL produce back-to-back acks with no stall.
REQ-017 Reads SHALL return register contents as held at the request cycle (pre-increment), registered into o_rdata.
REQ-018 o_rdata SHALL be 0 whenever o_ack=0.
REQ-019 Writes SHALL take effect at the clock edge ending the request cycle.
REQ-020 A prescaler counter SHALL count 0..PRESCALE-1, and the tick SHALL assert in the cycle the count equals PRESCALE-1, after which the count wraps to 0.
REQ-021 On a tick, mtime SHALL increment by 1 as a 64-bit unsigned value, with carry from [31:0] into [63:32].
REQ-022 0xFFFFFFFF_FFFFFFFF SHALL wrap to 0.
REQ-023 A write to either mtime half in a tick cycle SHALL win: the written half SHALL take the written value, the other half SHALL be held, no increment SHALL occur that cycle, and the prescaler SHALL continue counting.
REQ-024 o_timer_interrupt SHALL be a register loaded every cycle with (mtime >= mtimecmp), 64-bit unsigned, using current register values; it therefore changes one cycle after the registers change.
REQ-025 o_software_interrupt SHALL equal msip bit0 as a direct register output.
REQ-026 o_external_interrupt SHALL be i_ext_irq passed through a two-flop synchronizer, giving 2-cycle latency with no edge detection, level only.

Reset
REQ-027 When i_rst_n=0 at a rising edge, the following SHALL be set: mtime=0, mtimecmp=0xFFFFFFFF_FFFFFFFF, msip=0, prescaler=0, both synchronizer flops=0, o_timer_interrupt=0, o_ack=0, o_rdata=0.
REQ-028 A request presented during a reset cycle SHALL be dropped and SHALL NOT be acknowledged.
REQ-029 Reset applied mid-count SHALL restart the prescaler from 0.

Verification
REQ-030 Scenario: PRESCALE=1, release reset, read 0x10 in cycle 5 -> o_ack in cycle 6 with o_rdata=4, and o_rdata=0 in all non-ack cycles.
REQ-031 Scenario: write mtime lo=0xFFFFFFFE, hi=0x0, read both halves after 3 ticks -> lo=0x00000001, hi=0x00000001 (carry verified).
REQ-032 Scenario: write mtimecmp hi=0 then lo=0x20 with mtime below 0x20 -> o_timer_interrupt asserts 1 cycle after mtime reaches 0x20; then write mtimecmp hi=0xFFFFFFFF -> o_timer_interrupt deasserts 1 cycle after the write edge.
REQ-033 Scenario: write 0x00 with 0x3 then 0x0 -> o_software_interrupt=1 the cycle after the first write and 0 after the second; a read returns 0x1 between the writes.
REQ-034 Scenario: pulse i_ext_irq high for 5 cycles -> o_external_interrupt high for 5 cycles starting 2 cycles later; PRESCALE=4 shows mtime stepping once every 4 cycles.
REQ-035 Scenario: assert i_rst_n=0 for one cycle while i_req=1 and mtime=0x55 -> no ack, and on the following cycle mtime=0, mtimecmp all-ones, all outputs 0.

Source files
------------

// File: rtl/rv32i_clint.sv
// Core-local interruptor: msip, mtime and mtimecmp behind a one-cycle bus,
// plus the timer, software and external interrupt lines for the CSR unit.
module rv32i_clint #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  input  logic        i_ext_irq,
  output logic        o_timer_interrupt,
  output logic        o_software_interrupt,
  output logic        o_external_interrupt
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 64;
  localparam int unsigned PW = 16;

  localparam logic [AW-1:0] ADDR_MSIP      = AW'(5'h00);
  localparam logic [AW-1:0] ADDR_MTIMECMPL = AW'(5'h08);
  localparam logic [AW-1:0] ADDR_MTIMECMPH = AW'(5'h0C);
  localparam logic [AW-1:0] ADDR_MTIMEL    = AW'(5'h10);
  localparam logic [AW-1:0] ADDR_MTIMEH    = AW'(5'h14);

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] mtime_q, mtime_d;
  logic [TW-1:0] mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          sync1_q, sync2_q;
  logic          timer_q, timer_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          tick_c;
  logic          wr_c;
  logic          rd_c;
  logic [DW-1:0] rmux_c;

  assign tick_c = (presc_q == PRESC_MAX);
  assign wr_c   = i_req & i_we;
  assign rd_c   = i_req & ~i_we;

  // Read mux; full-address compare means unaligned offsets fall to zero.
  always_comb begin
    rmux_c = '0;
    case (i_addr)
      ADDR_MSIP:      rmux_c = DW'({31'b0, msip_q});
      ADDR_MTIMECMPL: rmux_c = mtimecmp_q[31:0];
      ADDR_MTIMECMPH: rmux_c = mtimecmp_q[63:32];
      ADDR_MTIMEL:    rmux_c = mtime_q[31:0];
      ADDR_MTIMEH:    rmux_c = mtime_q[63:32];
      default:        rmux_c = '0;
    endcase
  end

  // Next-state: a bus write to an mtime half overrides that cycle's increment.
  always_comb begin
    presc_d    = tick_c ? '0 : presc_q + PW'(1);
    mtime_d    = tick_c ? mtime_q + TW'(1) : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_c) begin
      case (i_addr)
        ADDR_MSIP:      msip_d = i_wdata[0];
        ADDR_MTIMECMPL: mtimecmp_d = {mtimecmp_q[63:32], i_wdata};
        ADDR_MTIMECMPH: mtimecmp_d = {i_wdata, mtimecmp_q[31:0]};
        ADDR_MTIMEL:    mtime_d = {mtime_q[63:32], i_wdata};
        ADDR_MTIMEH:    mtime_d = {i_wdata, mtime_q[31:0]};
        default:        ;
      endcase
    end
    timer_d = (mtime_q >= mtimecmp_q);
    ack_d   = i_req;
    rdata_d = rd_c ? rmux_c : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      timer_q    <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      sync1_q    <= i_ext_irq;
      sync2_q    <= sync1_q;
      timer_q    <= timer_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign o_ack                = ack_q;
  assign o_rdata              = rdata_q;
  assign o_timer_interrupt    = timer_q;
  assign o_software_interrupt = msip_q;
  assign o_external_interrupt = sync2_q;

endmodule

// File: tb/tb_rv32i_clint.sv
// Randomized scoreboard bench for rv32i_clint against an arithmetic timer model.
module tb_rv32i_clint;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [4:0]  i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_ext_irq = 1'b0;
  logic        o_ack;
  logic [31:0] o_rdata;
  logic        o_timer_interrupt;
  logic        o_software_interrupt;
  logic        o_external_interrupt;

  rv32i_clint #(.PRESCALE(P)) dut (
    .i_clk               (clk),
    .i_rst_n             (i_rst_n),
    .i_req               (i_req),
    .i_we                (i_we),
    .i_addr              (i_addr),
    .i_wdata             (i_wdata),
    .o_ack               (o_ack),
    .o_rdata             (o_rdata),
    .i_ext_irq           (i_ext_irq),
    .o_timer_interrupt   (o_timer_interrupt),
    .o_software_interrupt(o_software_interrupt),
    .o_external_interrupt(o_external_interrupt)
  );

  always #5 clk = ~clk;

  typedef struct { int tcyc; logic [31:0] data; } ack_t;
  typedef struct { int tcyc; logic t; logic s; logic e; } irq_t;

  ack_t ack_q[$];
  irq_t irq_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // Reference model: mtime = value last written + ticks elapsed since then.
  longint      n = 0;
  longint      base_cyc = 0;
  logic [63:0] base_val = '0;
  logic [63:0] m_cmp = '1;
  logic        m_msip = 1'b0;
  logic        prev_ext = 1'b0;
  logic        ext_lvl = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mtime_at(input longint nn);
    longint t;
    if (nn - 1 < base_cyc) t = 0;
    else t = nn / P - base_cyc / P;
    return base_val + 64'(t);
  endfunction

  task automatic step(input logic req, input logic we, input logic [4:0] addr,
                      input logic [31:0] wdata, input logic ext, input logic rst);
    logic [63:0] mt;
    ack_t a;
    irq_t r;
    @(posedge clk);
    #1;
    i_rst_n   = !rst;
    i_req     = req;
    i_we      = we;
    i_addr    = addr;
    i_wdata   = wdata;
    i_ext_irq = ext;
    r.tcyc = cyc + 1;
    if (rst) begin
      r.t = 1'b0; r.s = 1'b0; r.e = 1'b0;
      irq_q.push_back(r);
      n = 0; base_cyc = 0; base_val = '0; m_cmp = '1; m_msip = 1'b0; prev_ext = 1'b0;
    end else begin
      mt = mtime_at(n);
      r.t = (mt >= m_cmp);
      if (req) begin
        a.tcyc = cyc + 1;
        a.data = '0;
        if (!we) begin
          case (addr)
            5'h00: a.data = {31'b0, m_msip};
            5'h08: a.data = m_cmp[31:0];
            5'h0C: a.data = m_cmp[63:32];
            5'h10: a.data = mt[31:0];
            5'h14: a.data = mt[63:32];
            default: a.data = '0;
          endcase
        end else begin
          case (addr)
            5'h00: m_msip = wdata[0];
            5'h08: m_cmp[31:0] = wdata;
            5'h0C: m_cmp[63:32] = wdata;
            5'h10: begin base_val = {mt[63:32], wdata}; base_cyc = n + 1; end
            5'h14: begin base_val = {wdata, mt[31:0]}; base_cyc = n + 1; end
            default: ;
          endcase
        end
        ack_q.push_back(a);
      end
      r.s = m_msip;
      r.e = prev_ext;
      irq_q.push_back(r);
      prev_ext = ext;
      n++;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 5'h00, 32'h0, ext_lvl, 1'b0);
  endtask

  task automatic rd(input logic [4:0] addr);
    step(1'b1, 1'b0, addr, 32'h0, ext_lvl, 1'b0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    step(1'b1, 1'b1, addr, data, ext_lvl, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the queued expectations each cycle.
  always @(negedge clk) begin
    ack_t a;
    irq_t r;
    if (armed) begin
      if (o_ack === 1'b1) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected cyc=%0d rdata=%h", cyc, o_rdata);
        end else begin
          a = ack_q.pop_front();
          if (a.tcyc != cyc || o_rdata !== a.data) begin
            errors++;
            $display("FAIL ack_data cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, o_rdata, a.data, a.tcyc);
          end
        end
      end else begin
        checks++;
        if (o_ack !== 1'b0 || o_rdata !== 32'h0) begin
          errors++;
          $display("FAIL idle_rdata cyc=%0d ack=%b rdata=%h exp=0", cyc, o_ack, o_rdata);
        end
        if (ack_q.size() > 0 && ack_q[0].tcyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL ack_missing cyc=%0d exp_cyc=%0d", cyc, ack_q[0].tcyc);
          void'(ack_q.pop_front());
        end
      end
      if (irq_q.size() > 0 && irq_q[0].tcyc == cyc) begin
        r = irq_q.pop_front();
        checks++;
        if ({o_timer_interrupt, o_software_interrupt, o_external_interrupt} !== {r.t, r.s, r.e}) begin
          errors++;
          $display("FAIL irq cyc=%0d got t/s/e=%b%b%b exp=%b%b%b", cyc,
                   o_timer_interrupt, o_software_interrupt, o_external_interrupt, r.t, r.s, r.e);
        end
      end else if (irq_q.size() > 0 && irq_q[0].tcyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL irq_stale cyc=%0d exp_cyc=%0d", cyc, irq_q[0].tcyc);
        void'(irq_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] addrs [9];
    logic [4:0] ad;
    logic [31:0] wd;
    addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h11};

    step(1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 1'b1);
    armed = 1'b1;
    step(1'b1, 1'b0, 5'h10, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 5'h00, 32'h0, 1'b0, 1'b1);

    // Reset values and early counting
    rd(5'h10); rd(5'h14); rd(5'h08); rd(5'h0C); rd(5'h00);
    idle(10);
    rd(5'h10);
    rd(5'h1C); rd(5'h11);

    // Software interrupt
    wr(5'h00, 32'h3);
    rd(5'h00);
    wr(5'h00, 32'h0);
    rd(5'h00);

    // 32-bit carry and 64-bit wrap
    wr(5'h10, 32'hFFFF_FFFE);
    wr(5'h14, 32'h0);
    idle(12);
    rd(5'h10); rd(5'h14);
    wr(5'h14, 32'hFFFF_FFFF);
    wr(5'h10, 32'hFFFF_FFFF);
    idle(6);
    rd(5'h10); rd(5'h14);

    // Timer compare assert then deassert
    wr(5'h10, 32'h0);
    wr(5'h14, 32'h0);
    wr(5'h0C, 32'h0);
    wr(5'h08, 32'h20);
    idle(140);
    rd(5'h10);
    wr(5'h0C, 32'hFFFF_FFFF);
    idle(3);

    // External interrupt pulse
    ext_lvl = 1'b1; idle(5);
    ext_lvl = 1'b0; idle(4);

    // Reset mid-count with a pending request
    wr(5'h10, 32'h55);
    wr(5'h00, 32'h1);
    idle(1);
    step(1'b1, 1'b0, 5'h10, 32'h0, 1'b0, 1'b1);
    rd(5'h10); rd(5'h08); rd(5'h0C); rd(5'h00);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      ad = addrs[$urandom_range(0, 8)];
      wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
      if ($urandom_range(0, 7) == 0) ext_lvl = ~ext_lvl;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ad, wd, ext_lvl,
           ($urandom_range(0, 499) == 0));
    end

    idle(4);
    @(negedge clk);
    #1;
    checks++;
    if (ack_q.size() != 0 || irq_q.size() > 1) begin
      errors++;
      $display("FAIL drain ack_left=%0d irq_left=%0d", ack_q.size(), irq_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
